scene_ctrl: RTL and testbench

Frame-level sequencer for the scene restoration datapath `scene`. It accepts the pixel stream with frame markers and tracks the per-frame atmospheric-light estimate. It drives `scene` with each pixel, its 1/t value and the atmospheric light committed from the previous frame. It also delays frame markers so they stay aligned with the datapath output.

---
 rtl/scene_ctrl.sv | 160 ++++++++++++++++
 tb/tb_scene_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/scene_ctrl.sv
// Frame sequencer for the scene datapath: tracks the per-frame atmospheric-light candidate and drives scene.
// Latency: input accept -> dp_valid 1 cycle; accept -> o_valid/o_sof/o_eof 1+LAT cycles.
// Backpressure: none; scene must take one pixel per cycle. Pixels outside a frame are dropped and flagged.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_valid/i_sof/i_eof           pixel strobe and frame markers (markers qualified by i_valid)
//   i_r/i_g/i_b, i_on_by_t        pixel and its 1/t value
//   er/eg/eb, on_by_t, dp_valid   registered pixel drive to scene
//   Arlocal/Aglocal/Ablocal       atmospheric light committed by the previous frame
//   o_valid/o_sof/o_eof           markers delayed to line up with scene outputs
//   a_valid, frame_cnt            commit status
//   err_orphan, err_sof           sticky protocol error flags
module scene_ctrl #(
    parameter int             DW        = 8,
    parameter int             LAT       = 3,
    parameter logic [DW-1:0]  A_DEFAULT = '1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic          i_sof,
    input  logic          i_eof,
    input  logic [DW-1:0] i_r,
    input  logic [DW-1:0] i_g,
    input  logic [DW-1:0] i_b,
    input  logic [DW-1:0] i_on_by_t,
    output logic [DW-1:0] er,
    output logic [DW-1:0] eg,
    output logic [DW-1:0] eb,
    output logic [DW-1:0] on_by_t,
    output logic [DW-1:0] Arlocal,
    output logic [DW-1:0] Aglocal,
    output logic [DW-1:0] Ablocal,
    output logic          dp_valid,
    output logic          o_valid,
    output logic          o_sof,
    output logic          o_eof,
    output logic          a_valid,
    output logic [15:0]   frame_cnt,
    output logic          err_orphan,
    output logic          err_sof
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t        state, state_nxt;
    logic          accept, commit, orphan, restart, cand_load;
    logic [DW-1:0] dark, best_dark;
    logic [DW-1:0] cand_r, cand_g, cand_b;
    logic [DW-1:0] nx_r, nx_g, nx_b;
    logic [DW-1:0] a_app_r, a_app_g, a_app_b;
    logic          dp_sof, dp_eof;
    logic [2:0]    mk_pipe [LAT];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = i_eof ? S_IDLE : S_ACTIVE;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept  = i_valid & ((state == S_ACTIVE) | i_sof);
        orphan  = i_valid & (state == S_IDLE) & ~i_sof;
        restart = i_valid & (state == S_ACTIVE) & i_sof;
        commit  = accept & i_eof;
    end

    // Dark channel of the incoming pixel
    always_comb begin
        dark = i_r;
        if (i_g < dark) dark = i_g;
        if (i_b < dark) dark = i_b;
    end

    // A sof pixel always seeds the candidate; otherwise strict '>' keeps the first of equal darks.
    // nx_* is the candidate including this pixel, so an eof pixel can win its own commit.
    always_comb begin
        cand_load = accept & (i_sof | (dark > best_dark));
        nx_r = cand_load ? i_r : cand_r;
        nx_g = cand_load ? i_g : cand_g;
        nx_b = cand_load ? i_b : cand_b;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            best_dark  <= '0;
            cand_r     <= '0;
            cand_g     <= '0;
            cand_b     <= '0;
            a_app_r    <= A_DEFAULT;
            a_app_g    <= A_DEFAULT;
            a_app_b    <= A_DEFAULT;
            a_valid    <= 1'b0;
            frame_cnt  <= '0;
            err_orphan <= 1'b0;
            err_sof    <= 1'b0;
            dp_valid   <= 1'b0;
            dp_sof     <= 1'b0;
            dp_eof     <= 1'b0;
            er         <= '0;
            eg         <= '0;
            eb         <= '0;
            on_by_t    <= '0;
            Arlocal    <= A_DEFAULT;
            Aglocal    <= A_DEFAULT;
            Ablocal    <= A_DEFAULT;
        end else begin
            if (cand_load) begin
                best_dark <= dark;
                cand_r    <= i_r;
                cand_g    <= i_g;
                cand_b    <= i_b;
            end
            if (commit) begin
                a_app_r   <= nx_r;
                a_app_g   <= nx_g;
                a_app_b   <= nx_b;
                a_valid   <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (orphan)  err_orphan <= 1'b1;
            if (restart) err_sof    <= 1'b1;

            dp_valid <= accept;
            dp_sof   <= accept & i_sof;
            dp_eof   <= accept & i_eof;
            // Data holds when idle; A is the pre-edge value so the eof pixel still sees the old light.
            if (accept) begin
                er      <= i_r;
                eg      <= i_g;
                eb      <= i_b;
                on_by_t <= i_on_by_t;
                Arlocal <= a_app_r;
                Aglocal <= a_app_g;
                Ablocal <= a_app_b;
            end
        end
    end

    // Marker delay line matching the scene datapath latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < LAT; i++) mk_pipe[i] <= '0;
        end else begin
            mk_pipe[0] <= {dp_valid, dp_sof, dp_eof};
            for (int i = 1; i < LAT; i++) mk_pipe[i] <= mk_pipe[i-1];
        end
    end

    assign {o_valid, o_sof, o_eof} = mk_pipe[LAT-1];

endmodule

// File: tb/tb_scene_ctrl.sv
// Scoreboard bench for scene_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops them.
module tb_scene_ctrl;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_valid = 1'b0, i_sof = 1'b0, i_eof = 1'b0;
    logic [DW-1:0] i_r = '0, i_g = '0, i_b = '0, i_on_by_t = '0;
    logic [DW-1:0] er, eg, eb, on_by_t, Arlocal, Aglocal, Ablocal;
    logic          dp_valid, o_valid, o_sof, o_eof, a_valid, err_orphan, err_sof;
    logic [15:0]   frame_cnt;

    scene_ctrl #(.DW(DW), .LAT(LAT), .A_DEFAULT(8'hFF)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof), .i_eof(i_eof),
        .i_r(i_r), .i_g(i_g), .i_b(i_b), .i_on_by_t(i_on_by_t),
        .er(er), .eg(eg), .eb(eb), .on_by_t(on_by_t),
        .Arlocal(Arlocal), .Aglocal(Aglocal), .Ablocal(Ablocal),
        .dp_valid(dp_valid), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
        .a_valid(a_valid), .frame_cnt(frame_cnt), .err_orphan(err_orphan), .err_sof(err_sof)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] r, g, b, t, ar, ag, ab;
        int         c;
    } dp_t;
    typedef struct {
        logic s, e;
        int   c;
    } mk_t;

    dp_t dp_q[$];
    mk_t mk_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected output (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every presented output against the head of its queue
    always @(negedge i_clk) begin
        dp_t e;
        mk_t m;
        if (dp_valid) begin
            if (dp_q.size() == 0) fail_now("dp_unexpected");
            else begin
                e = dp_q.pop_front();
                chk("dp_pixel", {er, eg, eb, on_by_t}, {e.r, e.g, e.b, e.t});
                chk("dp_A", {8'h0, Arlocal, Aglocal, Ablocal}, {8'h0, e.ar, e.ag, e.ab});
                chk("dp_latency", cyc - e.c, 1);
            end
        end
        if (o_valid) begin
            if (mk_q.size() == 0) fail_now("mk_unexpected");
            else begin
                m = mk_q.pop_front();
                chk("mk_sof_eof", {o_sof, o_eof}, {m.s, m.e});
                chk("mk_latency", cyc - m.c, 1 + LAT);
            end
        end
    end

    // Drive one pixel; when acc is set the DUT must accept it and drive A=ar/ag/ab
    task automatic pix(input logic s, input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [7:0] t, input logic acc,
                       input logic [7:0] ar, input logic [7:0] ag, input logic [7:0] ab);
        @(posedge i_clk); #1;
        i_valid = 1'b1; i_sof = s; i_eof = e;
        i_r = r; i_g = g; i_b = b; i_on_by_t = t;
        if (acc) begin
            dp_q.push_back('{r, g, b, t, ar, ag, ab, cyc});
            mk_q.push_back('{s, e, cyc});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        dp_q.delete();
        mk_q.delete();
    endtask

    // Hard stop in case something never drains
    initial begin
        wait (cyc > 95000);
        $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Reset state
        chk("rst_valids", {dp_valid, o_valid, o_sof, o_eof}, 4'b0000);
        chk("rst_status", {a_valid, err_orphan, err_sof, frame_cnt}, 19'd0);
        chk("rst_data", {er, eg, eb, on_by_t}, 32'd0);
        chk("rst_A", {Arlocal, Aglocal, Ablocal}, 24'hFFFFFF);

        // Frame of darks 10,50,50,20: first dark-50 pixel (90,50,70) wins
        pix(1, 0,  10, 200, 100, 8'h11, 1, 8'hFF, 8'hFF, 8'hFF);
        pix(0, 0,  90,  50,  70, 8'h12, 1, 8'hFF, 8'hFF, 8'hFF);
        pix(0, 0,  50,  60,  80, 8'h13, 1, 8'hFF, 8'hFF, 8'hFF);
        pix(0, 1,  20,  30,  40, 8'h14, 1, 8'hFF, 8'hFF, 8'hFF);
        idle(1);
        chk("t1_frame_cnt", frame_cnt, 16'd1);
        chk("t1_a_valid", a_valid, 1'b1);
        pix(1, 1,   0,   0,   0, 8'h15, 1, 8'd90, 8'd50, 8'd70);
        idle(LAT + 3);

        // Back-to-back frames after reset
        do_reset();
        pix(1, 0, 100, 120, 110, 8'h21, 1, 8'hFF, 8'hFF, 8'hFF);
        pix(0, 1,  60,  60,  60, 8'h22, 1, 8'hFF, 8'hFF, 8'hFF);
        pix(1, 0,   5,   5,   5, 8'h23, 1, 8'd100, 8'd120, 8'd110);
        pix(0, 1, 200, 210, 220, 8'h24, 1, 8'd100, 8'd120, 8'd110);
        idle(1);
        chk("t2_frame_cnt", frame_cnt, 16'd2);

        // Single-cycle frame
        pix(1, 1,  40,  30,  20, 8'h31, 1, 8'd200, 8'd210, 8'd220);
        idle(1);
        chk("t3_frame_cnt", frame_cnt, 16'd3);
        idle(LAT + 2);

        // Orphan pixel, then mid-frame sof restart
        chk("t4_err_sof_clear", err_sof, 1'b0);
        pix(0, 0,  99,  99,  99, 8'h40, 0, 8'h00, 8'h00, 8'h00);
        idle(1);
        chk("t4_err_orphan", err_orphan, 1'b1);
        chk("t4_orphan_no_dp", dp_valid, 1'b0);
        pix(1, 0,  10,  10,  10, 8'h41, 1, 8'd40, 8'd30, 8'd20);
        pix(0, 0, 100, 100, 100, 8'h42, 1, 8'd40, 8'd30, 8'd20);
        pix(1, 0,  20,  25,  30, 8'h43, 1, 8'd40, 8'd30, 8'd20);
        idle(1);
        chk("t4_err_sof", err_sof, 1'b1);
        chk("t4_no_commit", frame_cnt, 16'd3);
        pix(0, 1,  15,  16,  17, 8'h44, 1, 8'd40, 8'd30, 8'd20);
        pix(1, 1,   1,   2,   3, 8'h45, 1, 8'd20, 8'd25, 8'd30);
        idle(1);
        chk("t4_frame_cnt", frame_cnt, 16'd5);
        chk("t4_flags_sticky", {err_orphan, err_sof}, 2'b11);
        idle(LAT + 3);

        // Reset at pixel 3 of a frame
        pix(1, 0,  50,  50,  50, 8'h51, 1, 8'd1, 8'd2, 8'd3);
        pix(0, 0,  60,  60,  60, 8'h52, 1, 8'd1, 8'd2, 8'd3);
        @(posedge i_clk); #1;
        i_rst = 1'b1; i_valid = 1'b1; i_sof = 1'b0; i_eof = 1'b1;
        i_r = 8'd70; i_g = 8'd70; i_b = 8'd70;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0; i_eof = 1'b0;
        mk_q.delete();
        chk("t5_valids", {dp_valid, o_valid, o_sof, o_eof}, 4'b0000);
        chk("t5_status", {a_valid, err_orphan, err_sof, frame_cnt}, 19'd0);
        pix(0, 0,  33,  33,  33, 8'h53, 0, 8'h00, 8'h00, 8'h00);
        pix(1, 1,   7,   8,   9, 8'h54, 1, 8'hFF, 8'hFF, 8'hFF);
        idle(1);
        chk("t5_frame_cnt", frame_cnt, 16'd1);
        chk("t5_orphan_after_rst", err_orphan, 1'b1);
        idle(LAT + 3);

        // Counter wrap over 65536 single-pixel frames
        do_reset();
        pix(1, 1, 40, 30, 20, 8'h00, 1, 8'hFF, 8'hFF, 8'hFF);
        for (int i = 1; i < 65535; i++)
            pix(1, 1, 40, 30, 20, i[7:0], 1, 8'd40, 8'd30, 8'd20);
        idle(1);
        chk("t6_cnt_ffff", frame_cnt, 16'hFFFF);
        pix(1, 1, 40, 30, 20, 8'hAA, 1, 8'd40, 8'd30, 8'd20);
        idle(1);
        chk("t6_cnt_wrap", frame_cnt, 16'h0000);
        chk("t6_a_valid", a_valid, 1'b1);

        // Everything issued must have come out
        idle(LAT + 4);
        chk("dp_q_drained", dp_q.size(), 0);
        chk("mk_q_drained", mk_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
